// File: rtl/cmos_i2c_pkg.sv
// Shared definitions for the CMOS I2C config loader: loader state encoding,
// config word width and the default table address width.
package cmos_i2c_pkg;

  // Config word layout: {ID[31:24], REGH[23:16], REGL[15:8], DATA[7:0]}
  localparam int CFG_WORD_W     = 32;
  // Default table address width (equals the timing controller index width)
  localparam int CFG_ADDR_W_DEF = 9;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } loader_state_t;

endpackage

// File: rtl/cmos_i2c_cfg_ram.sv
// Config table storage: simple dual-port RAM, DEPTH x CFG_WORD_W.
// Port A: synchronous write. Port B: synchronous read with a resettable
// output register so the data seen by the controller is 0 after reset.
module cmos_i2c_cfg_ram
  import cmos_i2c_pkg::*;
#(
  parameter int ADDR_W = CFG_ADDR_W_DEF,
  parameter int DEPTH  = 511
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [CFG_WORD_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [CFG_WORD_W-1:0] o_rd_data
);

  logic [CFG_WORD_W-1:0] r_mem [0:DEPTH-1];
  logic [CFG_WORD_W-1:0] r_rd_data;

  // Port A: host table write (contents are never reset)
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Port B: registered read every cycle, one cycle of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cmos_i2c_cfg_loader.sv
// CMOS I2C config loader: buffers a host-written table of config words,
// serves it by index to the I2C timing controller and (re)runs that
// controller by driving its reset, so sensor config can be reloaded at run
// time without a global reset.
//
// Optional feature: define CFG_LOADER_TIMEOUT_EN to add a RUN watchdog
// that aborts a run after TIMEOUT_CYC cycles and flags err_timeout.
//
// Host write handshake: a word transfers on a rising clk edge where both
// cfg_wr_valid and cfg_wr_ready are high; cfg_wr_ready depends only on
// loader state (never on cfg_wr_valid), and the host holds data/last
// stable while valid is high and ready is low.
module cmos_i2c_cfg_loader
  import cmos_i2c_pkg::*;
#(
  parameter int ADDR_W      = CFG_ADDR_W_DEF,
  parameter int DEPTH       = 511,
  parameter int ARM_CYC     = 16,
  parameter int TIMEOUT_CYC = 200_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_wr_valid,
  output logic                  cfg_wr_ready,
  input  logic [CFG_WORD_W-1:0] cfg_wr_data,
  input  logic                  cfg_wr_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow,
  output logic                  err_timeout,
  output logic                  ctrl_rst_n,
  output logic [ADDR_W-1:0]     i2c_config_size,
  input  logic [ADDR_W-1:0]     i2c_config_index,
  output logic [CFG_WORD_W-1:0] i2c_config_data,
  input  logic                  i2c_config_done
);

  localparam int                ARM_W    = $clog2(ARM_CYC);
  localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(ARM_CYC - 1);
  localparam logic [ADDR_W-1:0] DEPTH_V  = ADDR_W'(DEPTH);

  // Reject configurations the counters cannot represent
  if (ARM_CYC < 2 || TIMEOUT_CYC < 1 || DEPTH >= (2 ** ADDR_W)) begin : g_bad_cfg
    $error("cmos_i2c_cfg_loader: invalid ARM_CYC/TIMEOUT_CYC/DEPTH for ADDR_W");
  end

  loader_state_t     r_state;
  loader_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_size;
  logic [ARM_W-1:0]  r_arm_cnt;
  logic [1:0]        r_settle;
  logic              r_done;
  logic              r_err_overflow;
  logic              r_ctrl_rst_n;

  logic w_beat;
  logic w_enter_load;
  logic w_load_last;
  logic w_load_full;
  logic w_arm_end;
  logic w_run_done;
  logic w_run_tmo;
  logic w_tmo_hit;
  logic w_settled;

  assign cfg_wr_ready = (r_state == ST_LOAD) && (r_wr_ptr < DEPTH_V);
  assign w_beat       = cfg_wr_valid && cfg_wr_ready;
  // Controller index needs two cycles after release before its done is trusted
  assign w_settled    = (r_settle == 2'd2);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus one-cycle event strobes for the datapath
  always_comb begin
    w_state_nxt  = r_state;
    w_enter_load = 1'b0;
    w_load_last  = 1'b0;
    w_load_full  = 1'b0;
    w_arm_end    = 1'b0;
    w_run_done   = 1'b0;
    w_run_tmo    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (cfg_start) begin
          w_state_nxt  = ST_LOAD;
          w_enter_load = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_beat && cfg_wr_last) begin
          w_state_nxt = ST_ARM;
          w_load_last = 1'b1;
        end else if (r_wr_ptr == DEPTH_V) begin
          w_state_nxt = ST_ARM;
          w_load_full = 1'b1;
        end
      end
      ST_ARM: begin
        if (r_arm_cnt == ARM_LAST) begin
          w_state_nxt = ST_RUN;
          w_arm_end   = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_tmo_hit) begin
          w_state_nxt = ST_DONE;
          w_run_tmo   = 1'b1;
        end else if (w_settled && i2c_config_done) begin
          w_state_nxt = ST_DONE;
          w_run_done  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write pointer and loaded-table size
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_size   <= '0;
    end else begin
      if (w_enter_load) begin
        r_wr_ptr <= '0;
      end else if (w_beat) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load_last) begin
        r_size <= r_wr_ptr + 1'b1;
      end else if (w_load_full) begin
        r_size <= DEPTH_V;
      end
    end
  end

  // ARM hold counter and post-release settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm_cnt <= '0;
      r_settle  <= '0;
    end else begin
      if (w_load_last || w_load_full) begin
        r_arm_cnt <= '0;
      end else if (r_state == ST_ARM) begin
        r_arm_cnt <= r_arm_cnt + 1'b1;
      end
      if (w_arm_end) begin
        r_settle <= '0;
      end else if (r_state == ST_RUN && !w_settled) begin
        r_settle <= r_settle + 1'b1;
      end
    end
  end

  // Status flags and controller reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done         <= 1'b0;
      r_err_overflow <= 1'b0;
      r_ctrl_rst_n   <= 1'b0;
    end else begin
      if (w_enter_load) begin
        r_done         <= 1'b0;
        r_err_overflow <= 1'b0;
        r_ctrl_rst_n   <= 1'b0;
      end
      if (w_load_full) begin
        r_err_overflow <= 1'b1;
      end
      if (w_arm_end) begin
        r_ctrl_rst_n <= 1'b1;
      end
      if (w_run_done) begin
        r_done <= 1'b1;
      end
      if (w_run_tmo) begin
        r_done       <= 1'b1;
        r_ctrl_rst_n <= 1'b0;
      end
    end
  end

`ifdef CFG_LOADER_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  logic [31:0] r_wdog;
  logic        r_err_timeout;

  assign w_tmo_hit   = (r_state == ST_RUN) && (r_wdog == TMO_LAST);
  assign err_timeout = r_err_timeout;

  // RUN watchdog: restarts whenever the loader is outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state != ST_RUN) begin
      r_wdog <= '0;
    end else if (!w_tmo_hit) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Sticky timeout flag, cleared by the next table load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_timeout <= 1'b0;
    end else if (w_enter_load) begin
      r_err_timeout <= 1'b0;
    end else if (w_run_tmo) begin
      r_err_timeout <= 1'b1;
    end
  end
`else
  assign w_tmo_hit   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  cmos_i2c_cfg_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_beat),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (cfg_wr_data),
    .i_rd_addr (i2c_config_index),
    .o_rd_data (i2c_config_data)
  );

  assign busy            = (r_state == ST_LOAD) || (r_state == ST_ARM) || (r_state == ST_RUN);
  assign done            = r_done;
  assign err_overflow    = r_err_overflow;
  assign ctrl_rst_n      = r_ctrl_rst_n;
  assign i2c_config_size = r_size;

endmodule

// File: tb/tb_cmos_i2c_cfg_loader.sv
// Bench for cmos_i2c_cfg_loader. Host writes and a simple controller model
// drive the DUT; every controller read pushes the table word the reference
// table says it must return, and a monitor compares i2c_config_data one
// cycle later. Build with CFG_LOADER_TIMEOUT_EN to cover the watchdog.
module tb_cmos_i2c_cfg_loader;

  localparam int ADDR_W      = 9;
  localparam int DEPTH       = 511;
  localparam int ARM_CYC     = 16;
  localparam int TIMEOUT_CYC = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic              cfg_wr_valid = 1'b0;
  logic              cfg_wr_ready;
  logic [31:0]       cfg_wr_data = '0;
  logic              cfg_wr_last = 1'b0;
  logic              busy;
  logic              done;
  logic              err_overflow;
  logic              err_timeout;
  logic              ctrl_rst_n;
  logic [ADDR_W-1:0] i2c_config_size;
  logic [ADDR_W-1:0] i2c_config_index = '0;
  logic [31:0]       i2c_config_data;
  logic              i2c_config_done = 1'b0;

  // Scoreboard state and reference table (words the host got accepted)
  logic [31:0] exp_q[$];
  logic [31:0] model_tab [0:DEPTH-1];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        ctl_rd   = 1'b0;
  logic        rd_seen  = 1'b0;

  // Clock
  always #5 clk = ~clk;

  cmos_i2c_cfg_loader #(
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .ARM_CYC     (ARM_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start        (cfg_start),
    .cfg_wr_valid     (cfg_wr_valid),
    .cfg_wr_ready     (cfg_wr_ready),
    .cfg_wr_data      (cfg_wr_data),
    .cfg_wr_last      (cfg_wr_last),
    .busy             (busy),
    .done             (done),
    .err_overflow     (err_overflow),
    .err_timeout      (err_timeout),
    .ctrl_rst_n       (ctrl_rst_n),
    .i2c_config_size  (i2c_config_size),
    .i2c_config_index (i2c_config_index),
    .i2c_config_data  (i2c_config_data),
    .i2c_config_done  (i2c_config_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A read issued before a posedge shows up on i2c_config_data after it
  always @(posedge clk) rd_seen <= ctl_rd;

  // Monitor: compare every presented read against the scoreboard head
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check("rd_data", i2c_config_data, exp_q.pop_front());
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(cfg_wr_ready), 32'd0);
    check({tag, "_busy"},  32'(busy),         32'd0);
    check({tag, "_done"},  32'(done),         32'd0);
    check({tag, "_ovf"},   32'(err_overflow), 32'd0);
    check({tag, "_tmo"},   32'(err_timeout),  32'd0);
    check({tag, "_crst"},  32'(ctrl_rst_n),   32'd0);
    check({tag, "_size"},  32'(i2c_config_size), 32'd0);
    check({tag, "_data"},  i2c_config_data,   32'd0);
  endtask

  task automatic start_load();
    @(negedge clk);
    cfg_start        = 1'b1;
    i2c_config_done  = 1'b0;
    i2c_config_index = '0;
    @(negedge clk);
    cfg_start = 1'b0;
    check("ld_busy",  32'(busy),         32'd1);
    check("ld_done",  32'(done),         32'd0);
    check("ld_ovf",   32'(err_overflow), 32'd0);
    check("ld_tmo",   32'(err_timeout),  32'd0);
    check("ld_crst",  32'(ctrl_rst_n),   32'd0);
    check("ld_ready", 32'(cfg_wr_ready), 32'd1);
  endtask

  // Host driver: n words with random valid gaps; optional cfg_start pulse
  // alongside word start_at (must be ignored in LOAD)
  task automatic send_words(input int n, input bit with_last, input int start_at);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      cfg_start = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        cfg_wr_valid = 1'b0;
        cfg_wr_last  = 1'b0;
      end else begin
        cfg_wr_valid = 1'b1;
        cfg_wr_data  = $urandom();
        cfg_wr_last  = with_last && (sent == n - 1);
        if (sent == start_at) cfg_start = 1'b1;
        if (cfg_wr_ready) begin
          model_tab[sent] = cfg_wr_data;
          sent++;
        end
      end
    end
    if (sent != n) check("send_timeout", 32'(sent), 32'(n));
  endtask

  // After the final beat: ARM hold length, size and overflow flag
  task automatic finish_load(input int n, input bit with_last);
    int lowcnt   = 0;
    int exp_size = with_last ? n : DEPTH;
    if (!with_last) begin
      @(negedge clk);
      check("full_ready", 32'(cfg_wr_ready), 32'd0);
      check("full_crst",  32'(ctrl_rst_n),   32'd0);
      lowcnt = 1;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cfg_wr_valid = 1'b0;
      cfg_wr_last  = 1'b0;
      cfg_start    = 1'b0;
      if (ctrl_rst_n) break;
      lowcnt++;
    end
    check("release_seen", 32'(ctrl_rst_n), 32'd1);
    if (with_last) begin
      check("arm_len", 32'(lowcnt), 32'(ARM_CYC));
    end else begin
      check("arm_len_ovf", 32'(lowcnt >= ARM_CYC && lowcnt <= ARM_CYC + 1), 32'd1);
    end
    check("size", 32'(i2c_config_size), 32'(exp_size));
    check("ovf_flag", 32'(err_overflow), 32'(!with_last));
  endtask

  // Controller reports done during the first two RUN cycles: must be ignored
  task automatic glitch_done();
    i2c_config_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i2c_config_done = 1'b0;
    check("settle_busy", 32'(busy), 32'd1);
    check("settle_done", 32'(done), 32'd0);
  endtask

  // Controller model: steps index 0..size-1 with random dwell
  task automatic run_reads(input int size, input int start_at);
    for (int i = 0; i < size; i++) begin
      int dwell = (size > 50) ? 1 : int'($urandom_range(1, 3));
      for (int d = 0; d < dwell; d++) begin
        @(negedge clk);
        cfg_start        = (i == start_at) && (d == 0);
        i2c_config_index = ADDR_W'(i);
        ctl_rd           = 1'b1;
        exp_q.push_back(model_tab[i]);
      end
    end
    @(negedge clk);
    cfg_start        = 1'b0;
    ctl_rd           = 1'b0;
    i2c_config_index = ADDR_W'(size);
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("run_crst",   32'(ctrl_rst_n),   32'd1);
  endtask

  task automatic finish_run();
    i2c_config_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("fin_done", 32'(done),       32'd1);
    check("fin_busy", 32'(busy),       32'd0);
    check("fin_crst", 32'(ctrl_rst_n), 32'd1);
    check("fin_tmo",  32'(err_timeout), 32'd0);
  endtask

  initial begin
    int n;
    int tcnt;
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("idle");

    // Three-word table, full run
    start_load();
    send_words(3, 1'b1, -1);
    finish_load(3, 1'b1);
    glitch_done();
    run_reads(3, -1);
    finish_run();

    // Reload from DONE; full table without last -> overflow
    start_load();
    send_words(DEPTH, 1'b0, -1);
    finish_load(DEPTH, 1'b0);
    glitch_done();
    run_reads(DEPTH, -1);
    finish_run();
    check("ovf_sticky", 32'(err_overflow), 32'd1);

    // Reload clears overflow; cfg_start pulses in LOAD and RUN are ignored
    start_load();
    n = $urandom_range(5, 40);
    send_words(n, 1'b1, n / 2);
    finish_load(n, 1'b1);
    glitch_done();
    run_reads(n, n / 3);
    finish_run();

    // Async reset in the middle of RUN
    start_load();
    send_words(4, 1'b1, -1);
    finish_load(4, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean restart with a single-entry table
    start_load();
    send_words(1, 1'b1, -1);
    finish_load(1, 1'b1);
    glitch_done();
    run_reads(1, -1);
    finish_run();

    // Controller never completes
    start_load();
    send_words(2, 1'b1, -1);
    finish_load(2, 1'b1);
    tcnt = 1;
`ifdef CFG_LOADER_TIMEOUT_EN
    for (int i = 0; i < 2 * TIMEOUT_CYC; i++) begin
      @(negedge clk);
      if (done) break;
      tcnt++;
    end
    check("tmo_len",  32'(tcnt),         32'(TIMEOUT_CYC));
    check("tmo_flag", 32'(err_timeout),  32'd1);
    check("tmo_done", 32'(done),         32'd1);
    check("tmo_busy", 32'(busy),         32'd0);
    check("tmo_crst", 32'(ctrl_rst_n),   32'd0);
    start_load();
`else
    for (int i = 0; i < TIMEOUT_CYC + 200; i++) begin
      @(negedge clk);
      if (done) break;
      tcnt++;
    end
    check("hang_len",  32'(tcnt),        32'(TIMEOUT_CYC + 201));
    check("hang_busy", 32'(busy),        32'd1);
    check("hang_done", 32'(done),        32'd0);
    check("hang_tmo",  32'(err_timeout), 32'd0);
    check("hang_crst", 32'(ctrl_rst_n),  32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
